// File: rtl/bcp_sched.sv
// Pass sequencer for one BCP PE: pops a decision literal, streams the clause set through the PE, and routes
// each result to recirc, to the UCQ or drops it. A clause fires only when CLQ has data and UCQ/recirc have room.
module bcp_sched #(
   parameter int LIT_W = 8,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_clauses,
   input  logic             ucq_empty,
   input  logic             ucq_full,
   input  logic [LIT_W-1:0] ucq_head,
   output logic             ucq_pop,
   output logic             ucq_push,
   output logic [LIT_W-1:0] ucq_push_lit,
   input  logic             clq_empty,
   output logic             clq_pop,
   input  logic             recirc_full,
   output logic             recirc_push,
   output logic [LIT_W-1:0] pe_lit,
   input  logic             pe_imply,
   input  logic [LIT_W-1:0] pe_imply_idx,
   input  logic             pe_done,
   input  logic             pe_conflict,
   output logic             busy,
   output logic             res_sat,
   output logic             res_conflict,
   output logic             res_quiet,
   output logic [CNT_W-1:0] pass_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      STREAM,
      SAT,
      CONFLICT,
      QUIET
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LIT_W-1:0] pe_lit_nxt;
   logic [CNT_W-1:0] active;
   logic [CNT_W-1:0] active_nxt;
   logic [CNT_W-1:0] processed;
   logic [CNT_W-1:0] processed_nxt;
   logic [CNT_W-1:0] kept;
   logic [CNT_W-1:0] kept_nxt;
   logic [CNT_W-1:0] kept_inc;
   logic [CNT_W-1:0] pass_cnt_nxt;
   logic             res_sat_nxt;
   logic             res_conflict_nxt;
   logic             res_quiet_nxt;
   logic             fire;

   assign busy = (state == FETCH) || (state == STREAM);

   always_comb begin
      state_nxt        = state;
      pe_lit_nxt       = pe_lit;
      active_nxt       = active;
      processed_nxt    = processed;
      kept_nxt         = kept;
      kept_inc         = kept;
      pass_cnt_nxt     = pass_cnt;
      res_sat_nxt      = res_sat;
      res_conflict_nxt = res_conflict;
      res_quiet_nxt    = res_quiet;
      fire             = 1'b0;
      ucq_pop          = 1'b0;
      ucq_push         = 1'b0;
      ucq_push_lit     = '0;
      clq_pop          = 1'b0;
      recirc_push      = 1'b0;

      case (state)
         IDLE, SAT, CONFLICT, QUIET: begin
            if (start) begin
               res_sat_nxt      = 1'b0;
               res_conflict_nxt = 1'b0;
               res_quiet_nxt    = 1'b0;
               pass_cnt_nxt     = '0;
               active_nxt       = num_clauses;
               if (num_clauses == '0) begin
                  state_nxt   = SAT;
                  res_sat_nxt = 1'b1;
               end else begin
                  state_nxt = FETCH;
               end
            end
         end

         FETCH: begin
            if (active == '0) begin
               state_nxt   = SAT;
               res_sat_nxt = 1'b1;
            end else if (ucq_empty) begin
               state_nxt     = QUIET;
               res_quiet_nxt = 1'b1;
            end else begin
               ucq_pop       = 1'b1;
               pe_lit_nxt    = ucq_head;
               processed_nxt = '0;
               kept_nxt      = '0;
               state_nxt     = STREAM;
            end
         end

         STREAM: begin
            fire    = !clq_empty && !ucq_full && !recirc_full;
            clq_pop = fire;
            // A conflict ends the run outright, even on the last clause of a pass.
            if (fire && pe_conflict) begin
               state_nxt        = CONFLICT;
               res_conflict_nxt = 1'b1;
            end else if (fire) begin
               if (!pe_done) begin
                  if (pe_imply) begin
                     ucq_push     = 1'b1;
                     ucq_push_lit = pe_imply_idx;
                  end else begin
                     recirc_push = 1'b1;
                     kept_inc    = kept + CNT_ONE;
                  end
               end
               kept_nxt      = kept_inc;
               processed_nxt = processed + CNT_ONE;
               if (processed == active - CNT_ONE) begin
                  active_nxt = kept_inc;
                  if (pass_cnt != CNT_MAX) begin
                     pass_cnt_nxt = pass_cnt + CNT_ONE;
                  end
                  state_nxt = FETCH;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pe_lit       <= '0;
         pass_cnt     <= '0;
         active       <= '0;
         processed    <= '0;
         kept         <= '0;
         res_sat      <= 1'b0;
         res_conflict <= 1'b0;
         res_quiet    <= 1'b0;
      end else begin
         state        <= state_nxt;
         pe_lit       <= pe_lit_nxt;
         pass_cnt     <= pass_cnt_nxt;
         active       <= active_nxt;
         processed    <= processed_nxt;
         kept         <= kept_nxt;
         res_sat      <= res_sat_nxt;
         res_conflict <= res_conflict_nxt;
         res_quiet    <= res_quiet_nxt;
      end
   end

   a_no_push_pop: assert property (@(posedge clk) disable iff (!rst_n) !(ucq_push && ucq_pop));
   a_clq_pop_ok:  assert property (@(posedge clk) disable iff (!rst_n) clq_pop |-> !clq_empty);
   a_ucq_pop_ok:  assert property (@(posedge clk) disable iff (!rst_n) ucq_pop |-> !ucq_empty);

endmodule

// File: tb/tb_bcp_sched.sv
// Scoreboard bench for bcp_sched: a pass-level reference model predicts UCQ/recirc/result events, and a
// negedge monitor checks them while the bench plays UCQ, CLQ/recirc and PE around the DUT.
module tb_bcp_sched;
   localparam int LIT_W = 8;
   localparam int CNT_W = 10;
   localparam int K_OTHER = 0, K_DONE = 1, K_IMPLY = 2, K_CONF = 3;
   localparam int E_POP = 0, E_PUSH = 1, E_RECIRC = 2, E_END = 3;
   localparam int R_SAT = 1, R_CONF = 2, R_QUIET = 4;

   typedef struct {
      int kind;
      int val;
      int aux;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_clauses = '0;
   logic             ucq_empty = 1'b1;
   logic             ucq_full = 1'b0;
   logic [LIT_W-1:0] ucq_head = '0;
   logic             ucq_pop;
   logic             ucq_push;
   logic [LIT_W-1:0] ucq_push_lit;
   logic             clq_empty = 1'b1;
   logic             clq_pop;
   logic             recirc_full = 1'b0;
   logic             recirc_push;
   logic [LIT_W-1:0] pe_lit;
   logic             pe_imply = 1'b0;
   logic [LIT_W-1:0] pe_imply_idx = '0;
   logic             pe_done = 1'b0;
   logic             pe_conflict = 1'b0;
   logic             busy;
   logic             res_sat;
   logic             res_conflict;
   logic             res_quiet;
   logic [CNT_W-1:0] pass_cnt;

   bcp_sched #(.LIT_W(LIT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_clauses(num_clauses),
      .ucq_empty(ucq_empty), .ucq_full(ucq_full), .ucq_head(ucq_head),
      .ucq_pop(ucq_pop), .ucq_push(ucq_push), .ucq_push_lit(ucq_push_lit),
      .clq_empty(clq_empty), .clq_pop(clq_pop), .recirc_full(recirc_full),
      .recirc_push(recirc_push), .pe_lit(pe_lit), .pe_imply(pe_imply),
      .pe_imply_idx(pe_imply_idx), .pe_done(pe_done), .pe_conflict(pe_conflict),
      .busy(busy), .res_sat(res_sat), .res_conflict(res_conflict),
      .res_quiet(res_quiet), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   // Test configuration, owned by the stimulus process.
   int  cfg_n;
   int  cfg_ucq[$];
   int  cfg_kind[64];
   int  cfg_imp[64];
   bit  use_table;
   int  salt, conf_pct, done_pct, imply_pct;
   int  stall_pct, rf_pct, uf_pct;
   int  rf_from, rf_len, uf_from, uf_len;
   int  mid_start_at;
   int  exp_cycles;
   int  start_cnt = 0;
   bit  rst_chk = 1'b0;
   ev_t sb[$];

   // Environment and result state, owned by the monitor process.
   int env_ucq[$];
   int env_clq[$];
   int checks = 0;
   int failures = 0;
   int end_cnt = 0;
   int run_cyc, busy_cyc, cur_lit;

   // PE behaviour: a clause's response depends only on its id and the decision literal.
   function automatic int resp_kind(int c, int lit);
      int x;
      if (use_table) return cfg_kind[c];
      x = (c * 37 + (lit & 255) * 11 + salt) % 100;
      if (x < conf_pct) return K_CONF;
      if (x < conf_pct + done_pct) return K_DONE;
      if (x < conf_pct + done_pct + imply_pct) return K_IMPLY;
      return K_OTHER;
   endfunction

   function automatic int resp_imp(int c, int lit);
      int v;
      if (use_table) return cfg_imp[c];
      v = ((c * 13 + (lit & 255) * 5 + salt) % 100) + 1;
      return (((c + lit) % 2) != 0) ? -v : v;
   endfunction

   function automatic void push_ev(int kind, int val, int aux);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.aux  = aux;
      sb.push_back(e);
   endfunction

   // Reference model: whole passes over a list of clause ids, counting busy cycles.
   task automatic build_expect(output int cyc);
      int ucq[$];
      int clq[$];
      int active, pass, kept, lit, c, k;
      bit fin;
      sb.delete();
      ucq = cfg_ucq;
      for (int i = 0; i < cfg_n; i++) clq.push_back(i);
      active = cfg_n;
      pass   = 0;
      cyc    = 0;
      fin    = (cfg_n == 0);
      if (cfg_n == 0) push_ev(E_END, R_SAT, 0);
      while (!fin) begin
         cyc++;
         if (active == 0) begin
            push_ev(E_END, R_SAT, pass);
            fin = 1'b1;
         end else if (ucq.size() == 0) begin
            push_ev(E_END, R_QUIET, pass);
            fin = 1'b1;
         end else begin
            lit = ucq.pop_front();
            push_ev(E_POP, lit, 0);
            kept = 0;
            for (int i = 0; i < active && !fin; i++) begin
               cyc++;
               c = clq.pop_front();
               k = resp_kind(c, lit);
               if (k == K_CONF) begin
                  push_ev(E_END, R_CONF, pass);
                  fin = 1'b1;
               end else if (k == K_IMPLY) begin
                  push_ev(E_PUSH, resp_imp(c, lit), 0);
                  ucq.push_back(resp_imp(c, lit));
               end else if (k == K_OTHER) begin
                  push_ev(E_RECIRC, c, 0);
                  clq.push_back(c);
                  kept++;
               end
            end
            if (!fin) begin
               active = kept;
               if (pass < 1023) pass++;
            end
         end
      end
   endtask

   task automatic drive_env(input int k);
      int c, kd, lit;
      bit blk;
      ucq_empty    = (env_ucq.size() == 0);
      ucq_head     = ucq_empty ? '0 : LIT_W'(env_ucq[0]);
      ucq_full     = ($urandom_range(99) < uf_pct) || (k >= uf_from && k < uf_from + uf_len);
      recirc_full  = ($urandom_range(99) < rf_pct) || (k >= rf_from && k < rf_from + rf_len);
      clq_empty    = (env_clq.size() == 0) || ($urandom_range(99) < stall_pct);
      blk          = ucq_full || recirc_full || clq_empty;
      pe_imply_idx = LIT_W'($urandom);
      pe_imply     = ($urandom_range(1) == 1);
      pe_done      = ($urandom_range(1) == 1);
      pe_conflict  = ($urandom_range(1) == 1);
      if (!blk) begin
         c           = env_clq[0];
         lit         = int'($signed(pe_lit));
         kd          = resp_kind(c, lit);
         pe_conflict = (kd == K_CONF);
         pe_done     = (kd == K_DONE) || (kd == K_CONF && $urandom_range(1) == 1);
         pe_imply    = (kd == K_IMPLY) || (kd != K_OTHER && $urandom_range(1) == 1);
         if (kd == K_IMPLY) pe_imply_idx = LIT_W'(resp_imp(c, lit));
      end
   endtask

   task automatic set_defaults();
      use_table = 1'b0; salt = 0; conf_pct = 0; done_pct = 0; imply_pct = 0;
      stall_pct = 0; rf_pct = 0; uf_pct = 0;
      rf_from = -100; rf_len = 0; uf_from = -100; uf_len = 0;
      mid_start_at = -1;
      cfg_ucq.delete();
   endtask

   task automatic run_test(input int n, input int exp_stall, input bit cyc_chk);
      int model_cyc, k;
      cfg_n = n;
      build_expect(model_cyc);
      exp_cycles = cyc_chk ? model_cyc + exp_stall : -1;
      @(posedge clk); #1;
      num_clauses = CNT_W'(n);
      start = 1'b1;
      drive_env(-1);
      @(posedge clk); #1;
      start = 1'b0;
      start_cnt++;
      k = 0;
      drive_env(k);
      while (end_cnt != start_cnt) begin
         @(posedge clk); #1;
         k++;
         if (k == mid_start_at) begin
            start       = 1'b1;
            num_clauses = '0;
         end else begin
            start = 1'b0;
         end
         drive_env(k);
         if (k > 6000) begin
            $display("FAIL run_timeout: run %0d never ended, required end within 6000 cycles", start_cnt);
            $fatal(1);
         end
      end
      start = 1'b0;
   endtask

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (run %0d)", name, act, exp, start_cnt);
      end
   endfunction

   function automatic int expect_ev(string name, int kind, int val);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s: got kind=%0d val=%0d, required nothing (scoreboard empty)", name, kind, val);
         return val;
      end
      e = sb.pop_front();
      if (e.kind != kind || e.val != val) begin
         failures++;
         $display("FAIL %s: got kind=%0d val=%0d, required kind=%0d val=%0d", name, kind, val, e.kind, e.val);
      end
      return e.val;
   endfunction

   initial begin : monitor
      ev_t e;
      int  c;
      bit  running;
      forever begin
         @(negedge clk);
         running = (start_cnt != end_cnt);
         if (rst_n && !running) begin
            if (start) begin
               env_ucq = cfg_ucq;
               env_clq.delete();
               for (int i = 0; i < cfg_n; i++) env_clq.push_back(i);
               run_cyc  = 0;
               busy_cyc = 0;
               cur_lit  = 0;
            end
            chk("idle_outputs", {ucq_pop, ucq_push, recirc_push, clq_pop, busy, ucq_push_lit}, 0);
            if (rst_chk) chk("reset_regs", {pe_lit, pass_cnt, res_sat, res_conflict, res_quiet}, 0);
         end else if (rst_n) begin
            run_cyc++;
            if (busy) busy_cyc++;
            if (ucq_pop) begin
               cur_lit = expect_ev("ucq_pop", E_POP, int'($signed(ucq_head)));
               if (env_ucq.size() > 0) void'(env_ucq.pop_front());
            end
            if (ucq_push) begin
               void'(expect_ev("ucq_push", E_PUSH, int'($signed(ucq_push_lit))));
               env_ucq.push_back(int'($signed(ucq_push_lit)));
            end
            if (clq_pop) begin
               chk("pe_lit", longint'($signed(pe_lit)), cur_lit);
               c = (env_clq.size() > 0) ? env_clq.pop_front() : -1;
               if (recirc_push) begin
                  void'(expect_ev("recirc_push", E_RECIRC, c));
                  env_clq.push_back(c);
               end
            end else if (recirc_push) begin
               chk("recirc_without_pop", recirc_push, 0);
            end
            if (ucq_full || recirc_full || clq_empty)
               chk("stall_no_activity", {clq_pop, ucq_push, recirc_push}, 0);
            if (res_sat || res_conflict || res_quiet) begin
               while (sb.size() > 0 && sb[0].kind != E_END) begin
                  e = sb.pop_front();
                  checks++;
                  failures++;
                  $display("FAIL missing_event: got run end, required kind=%0d val=%0d first", e.kind, e.val);
               end
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("result", {res_quiet, res_conflict, res_sat}, e.val);
                  chk("pass_cnt", pass_cnt, e.aux);
                  chk("busy_at_end", busy, 0);
                  if (exp_cycles >= 0) chk("busy_cycles", busy_cyc, exp_cycles);
               end else begin
                  chk("unexpected_end", {res_quiet, res_conflict, res_sat}, 0);
               end
               end_cnt = start_cnt;
            end else if (run_cyc > 4000) begin
               checks++;
               failures++;
               $display("FAIL run_end: got no result after %0d cycles, required a result", run_cyc);
               end_cnt = start_cnt;
            end
         end
      end
   end

   initial begin : stimulus
      int m, v;
      set_defaults();
      cfg_n = 0;
      exp_cycles = -1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      rst_chk = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_chk = 1'b0;

      // Empty clause set: straight to SAT.
      run_test(0, 0, 1'b1);

      // done/other/other on +1, then the UCQ runs dry.
      set_defaults();
      use_table = 1'b1;
      cfg_kind[0] = K_DONE; cfg_kind[1] = K_OTHER; cfg_kind[2] = K_OTHER;
      cfg_ucq.push_back(1);
      run_test(3, 0, 1'b1);

      // Two implications empty the clause set.
      set_defaults();
      use_table = 1'b1;
      cfg_kind[0] = K_IMPLY; cfg_imp[0] = -3;
      cfg_kind[1] = K_IMPLY; cfg_imp[1] = 4;
      cfg_ucq.push_back(2);
      run_test(2, 0, 1'b1);

      // Conflict on the second clause.
      set_defaults();
      use_table = 1'b1;
      cfg_kind[0] = K_OTHER; cfg_kind[1] = K_CONF; cfg_kind[2] = K_OTHER;
      cfg_ucq.push_back(5);
      run_test(3, 0, 1'b1);

      // recirc_full for 3 cycles mid-stream, plus a start pulse that must be ignored.
      set_defaults();
      use_table = 1'b1;
      for (int i = 0; i < 6; i++) cfg_kind[i] = K_OTHER;
      cfg_ucq.push_back(1);
      cfg_ucq.push_back(2);
      rf_from = 2; rf_len = 3;
      mid_start_at = 3;
      run_test(6, 3, 1'b1);

      // ucq_full while the imply clause is presented.
      set_defaults();
      use_table = 1'b1;
      cfg_kind[0] = K_IMPLY; cfg_imp[0] = 7;
      cfg_kind[1] = K_OTHER;
      cfg_ucq.push_back(3);
      uf_from = 1; uf_len = 2;
      run_test(2, 2, 1'b1);

      for (int t = 0; t < 40; t++) begin
         set_defaults();
         salt      = int'($urandom_range(999));
         conf_pct  = int'($urandom_range(6));
         done_pct  = int'($urandom_range(40, 10));
         imply_pct = int'($urandom_range(25, 5));
         if (t % 4 != 0) begin
            stall_pct = int'($urandom_range(15));
            rf_pct    = int'($urandom_range(15));
            uf_pct    = int'($urandom_range(15));
         end
         m = int'($urandom_range(3, 1));
         for (int i = 0; i < m; i++) begin
            v = int'($urandom_range(100, 1));
            cfg_ucq.push_back(($urandom_range(1) == 1) ? -v : v);
         end
         run_test(int'($urandom_range(24, 1)), 0, (t % 4 == 0));
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
